// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot cell pipeline.
// Used by the cell dispatch scheduler and its coordinate bus.
package mandelbrot_pkg;

  localparam int IDX_WIDTH   = 17;
  localparam int COORD_WIDTH = 64;

  // Marks "no cell on the bus" while the scheduler is idle
  localparam logic [IDX_WIDTH-1:0] IDX_NULL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_OFFER = 2'd2,
    ST_HOLD  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]   idx;
    logic [COORD_WIDTH-1:0] x0;
    logic [COORD_WIDTH-1:0] y0;
  } coord_entry_t;

endpackage

// File: rtl/cell_dispatch_scheduler_if.sv
// Coordinate bus between the coordinate generator, the scheduler and the workers.
// The slave modport is the scheduler's view; master is the generator/worker side.
interface cell_dispatch_scheduler_if
  import mandelbrot_pkg::*;
#(
  parameter int NUM_WORKERS = 4
);

  logic                   coord_valid;
  logic                   coord_ready;
  logic [IDX_WIDTH-1:0]   coord_idx;
  logic [COORD_WIDTH-1:0] coord_x0;
  logic [COORD_WIDTH-1:0] coord_y0;

  logic [NUM_WORKERS-1:0] poll_ready;
  logic [NUM_WORKERS-1:0] worker_read;
  logic [IDX_WIDTH-1:0]   idx_out;
  logic [COORD_WIDTH-1:0] x0_out;
  logic [COORD_WIDTH-1:0] y0_out;

  modport slave (
    input  coord_valid, coord_idx, coord_x0, coord_y0, worker_read,
    output coord_ready, poll_ready, idx_out, x0_out, y0_out
  );

  modport master (
    output coord_valid, coord_idx, coord_x0, coord_y0, worker_read,
    input  coord_ready, poll_ready, idx_out, x0_out, y0_out
  );

endinterface

// File: rtl/round_robin_pointer.sv
// Modulo-NUM_WORKERS pointer with advance enable and a one-hot decode of the
// current position.
module round_robin_pointer #(
  parameter int NUM_WORKERS = 4,
  parameter int PTR_WIDTH   = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   advance,
  output logic [NUM_WORKERS-1:0] onehot
);

  logic [PTR_WIDTH-1:0] ptr_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (advance) begin
      if (ptr_reg == PTR_WIDTH'(NUM_WORKERS - 1)) begin
        ptr_reg <= '0;
      end else begin
        ptr_reg <= ptr_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORKERS; gi++) begin : g_decode
      assign onehot[gi] = (ptr_reg == PTR_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/cell_dispatch_scheduler.sv
// Pops coordinate entries from the generator and offers each one to a single
// worker at a time, rotating the offer until a worker takes it.
module cell_dispatch_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int NUM_WORKERS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [IDX_WIDTH-1:0] frame_count,
  input  logic                 frame_abort,
  output logic                 busy,
  output logic                 frame_done,
  output logic [IDX_WIDTH-1:0] dispatched,
  output logic                 protocol_error,
  cell_dispatch_scheduler_if.slave bus
);

  sched_state_t           state_reg;
  sched_state_t           state_next;
  logic [IDX_WIDTH-1:0]   frame_count_reg;
  logic [IDX_WIDTH-1:0]   dispatched_reg;
  logic [IDX_WIDTH-1:0]   idx_reg;
  logic [COORD_WIDTH-1:0] x0_reg;
  logic [COORD_WIDTH-1:0] y0_reg;
  logic                   frame_done_reg;
  logic                   abort_pending_reg;
  logic                   protocol_error_reg;

  logic [NUM_WORKERS-1:0] ptr_onehot;
  logic [NUM_WORKERS-1:0] poll_ready;
  logic                   in_offer;
  logic                   grant;
  logic                   read_error;
  logic                   load_entry;
  logic                   start_frame;
  logic                   finish_frame;

  // The pointer moves on every offer cycle, whether or not the offer was taken,
  // so a worker that declines does not keep getting first pick.
  round_robin_pointer #(
    .NUM_WORKERS (NUM_WORKERS)
  ) u_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (in_offer),
    .onehot  (ptr_onehot)
  );

  assign in_offer   = (state_reg == ST_OFFER);
  assign poll_ready = in_offer ? ptr_onehot : '0;
  assign grant      = |(bus.worker_read & poll_ready);
  assign read_error = |(bus.worker_read & ~poll_ready);

  always_comb begin
    state_next   = state_reg;
    load_entry   = 1'b0;
    start_frame  = 1'b0;
    finish_frame = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
          if (frame_count != '0) begin
            state_next = ST_LOAD;
          end else begin
            finish_frame = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (frame_abort) begin
          state_next   = ST_IDLE;
          finish_frame = 1'b1;
        end else if (bus.coord_valid) begin
          load_entry = 1'b1;
          state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // A read in the same cycle as an abort still hands the entry out
        if (grant) begin
          state_next = ST_HOLD;
        end else if (frame_abort) begin
          state_next   = ST_IDLE;
          finish_frame = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort_pending_reg || frame_abort || (dispatched_reg == frame_count_reg)) begin
          state_next   = ST_IDLE;
          finish_frame = 1'b1;
        end else begin
          state_next = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      frame_count_reg    <= '0;
      dispatched_reg     <= '0;
      idx_reg            <= IDX_NULL;
      x0_reg             <= '0;
      y0_reg             <= '0;
      frame_done_reg     <= 1'b0;
      abort_pending_reg  <= 1'b0;
      protocol_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= finish_frame;

      if (read_error) begin
        protocol_error_reg <= 1'b1;
      end

      if (start_frame) begin
        frame_count_reg <= frame_count;
        dispatched_reg  <= '0;
      end else if (grant) begin
        dispatched_reg <= dispatched_reg + 1'b1;
      end

      if (grant && frame_abort) begin
        abort_pending_reg <= 1'b1;
      end else if (state_reg == ST_HOLD) begin
        abort_pending_reg <= 1'b0;
      end

      if (load_entry) begin
        idx_reg <= bus.coord_idx;
        x0_reg  <= bus.coord_x0;
        y0_reg  <= bus.coord_y0;
      end else if (finish_frame) begin
        idx_reg <= IDX_NULL;
      end
    end
  end

  assign bus.coord_ready = (state_reg == ST_LOAD);
  assign bus.poll_ready  = poll_ready;
  assign bus.idx_out     = idx_reg;
  assign bus.x0_out      = x0_reg;
  assign bus.y0_out      = y0_reg;

  assign busy           = (state_reg != ST_IDLE);
  assign frame_done     = frame_done_reg;
  assign dispatched     = dispatched_reg;
  assign protocol_error = protocol_error_reg;

endmodule

// File: tb/tb_cell_dispatch_scheduler.sv
// Randomized frame-level bench for cell_dispatch_scheduler; expected bus activity
// is derived from a transaction-level model of the dispatch rules.
module tb_cell_dispatch_scheduler;
  import mandelbrot_pkg::*;

  localparam int NW = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 frame_start = 1'b0;
  logic [IDX_WIDTH-1:0] frame_count = '0;
  logic                 frame_abort = 1'b0;
  logic                 busy;
  logic                 frame_done;
  logic [IDX_WIDTH-1:0] dispatched;
  logic                 protocol_error;

  cell_dispatch_scheduler_if #(.NUM_WORKERS(NW)) bus_if ();

  cell_dispatch_scheduler #(.NUM_WORKERS(NW)) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .frame_count    (frame_count),
    .frame_abort    (frame_abort),
    .busy           (busy),
    .frame_done     (frame_done),
    .dispatched     (dispatched),
    .protocol_error (protocol_error),
    .bus            (bus_if)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int frames = 0;

  // Model: offer position, entries handed out this frame, sticky error flag
  int m_ptr = 0;
  int m_disp = 0;
  bit m_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input bit e_busy, input bit e_cready,
                            input logic [NW-1:0] e_poll, input bit e_done);
    check({tag, ".busy"}, 64'(busy), 64'(e_busy));
    check({tag, ".coord_ready"}, 64'(bus_if.coord_ready), 64'(e_cready));
    check({tag, ".poll_ready"}, 64'(bus_if.poll_ready), 64'(e_poll));
    check({tag, ".frame_done"}, 64'(frame_done), 64'(e_done));
    check({tag, ".protocol_error"}, 64'(protocol_error), 64'(m_err));
  endtask

  task automatic check_entry(input string tag, input logic [IDX_WIDTH-1:0] e_idx,
                             input logic [63:0] e_x0, input logic [63:0] e_y0);
    check({tag, ".idx_out"}, 64'(bus_if.idx_out), 64'(e_idx));
    check({tag, ".x0_out"}, bus_if.x0_out, e_x0);
    check({tag, ".y0_out"}, bus_if.y0_out, e_y0);
  endtask

  task automatic check_frame_end(input string tag);
    check_outs(tag, 1'b0, 1'b0, '0, 1'b1);
    check({tag, ".idx_null"}, 64'(bus_if.idx_out), 64'(IDX_NULL));
    check({tag, ".dispatched"}, 64'(dispatched), 64'(m_disp));
    cycle();
    check_outs({tag, "_after"}, 1'b0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [NW-1:0] onehot(input int p);
    logic [NW-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // mode: 0 none, 1 abort in LOAD, 2 abort in OFFER without read,
  //       3 abort together with the read, 4 abort in HOLD (all at entry abort_k)
  // tgt_sel: <0 the polled worker reads at once, 0..NW-1 fixed reader, >=NW random
  task automatic run_frame(input int count, input int mode, input int abort_k,
                           input int tgt_sel, input int max_wait, input bit bad_read);
    logic [IDX_WIDTH-1:0] e_idx;
    logic [63:0]          e_x0;
    logic [63:0]          e_y0;
    bit                   aborting;
    bit                   granted;
    int                   tgt;
    int                   wait_n;

    frames++;
    frame_count = IDX_WIDTH'(count);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    frame_count = IDX_WIDTH'($urandom);
    if (count == 0) begin
      m_disp = 0;
      check_frame_end("zero_frame");
      $display("frame %0d count=0 done", frames);
      return;
    end
    m_disp = 0;
    aborting = 1'b0;
    for (int k = 0; k < count; k++) begin
      check_outs("load", 1'b1, 1'b1, '0, 1'b0);
      check("load.dispatched", 64'(dispatched), 64'(m_disp));
      if (mode == 1 && k == abort_k) begin
        frame_abort = 1'b1;
        cycle();
        frame_abort = 1'b0;
        check_frame_end("abort_load");
        $display("frame %0d aborted in load after %0d", frames, m_disp);
        return;
      end
      wait_n = $urandom_range(0, max_wait);
      for (int w = 0; w < wait_n; w++) begin
        // A new frame_start while busy must have no effect
        frame_start = 1'($urandom_range(0, 1));
        frame_count = IDX_WIDTH'($urandom);
        cycle();
        frame_start = 1'b0;
        check_outs("load_wait", 1'b1, 1'b1, '0, 1'b0);
      end
      e_idx = IDX_WIDTH'($urandom);
      e_x0  = {$urandom, $urandom};
      e_y0  = {$urandom, $urandom};
      bus_if.coord_valid = 1'b1;
      bus_if.coord_idx   = e_idx;
      bus_if.coord_x0    = e_x0;
      bus_if.coord_y0    = e_y0;
      cycle();
      bus_if.coord_valid = 1'b0;
      tgt = (tgt_sel < 0) ? -1 : ((tgt_sel >= NW) ? int'($urandom_range(0, NW - 1)) : tgt_sel);
      granted = 1'b0;
      for (int c = 0; c < 3 * NW && !granted; c++) begin
        check_outs("offer", 1'b1, 1'b0, onehot(m_ptr), 1'b0);
        check_entry("offer", e_idx, e_x0, e_y0);
        if (mode == 2 && k == abort_k) begin
          frame_abort = 1'b1;
          m_ptr = (m_ptr + 1) % NW;
          cycle();
          frame_abort = 1'b0;
          check_frame_end("abort_offer");
          $display("frame %0d aborted in offer after %0d", frames, m_disp);
          return;
        end
        if (bad_read && c == 0) begin
          bus_if.worker_read = onehot((m_ptr + 1) % NW);
          m_err = 1'b1;
          m_ptr = (m_ptr + 1) % NW;
          cycle();
          bus_if.worker_read = '0;
        end else if (tgt < 0 || tgt == m_ptr) begin
          bus_if.worker_read = onehot(m_ptr);
          if (mode == 3 && k == abort_k) begin
            frame_abort = 1'b1;
            aborting = 1'b1;
          end
          $display("frame %0d dispatch idx=%0h to worker %0d", frames, e_idx, m_ptr);
          m_ptr = (m_ptr + 1) % NW;
          m_disp++;
          granted = 1'b1;
          cycle();
          bus_if.worker_read = '0;
          frame_abort = 1'b0;
        end else begin
          // Upstream traffic while an entry is staged must not disturb it
          bus_if.coord_valid = 1'($urandom_range(0, 1));
          bus_if.coord_idx   = IDX_WIDTH'($urandom);
          m_ptr = (m_ptr + 1) % NW;
          cycle();
          bus_if.coord_valid = 1'b0;
        end
      end
      if (!granted) begin
        check("offer_timeout", 64'(0), 64'(1));
        return;
      end
      check_outs("hold", 1'b1, 1'b0, '0, 1'b0);
      check_entry("hold", e_idx, e_x0, e_y0);
      check("hold.dispatched", 64'(dispatched), 64'(m_disp));
      if (mode == 4 && k == abort_k) begin
        frame_abort = 1'b1;
        aborting = 1'b1;
      end
      cycle();
      frame_abort = 1'b0;
      if (aborting || m_disp == count) begin
        check_frame_end(aborting ? "abort_end" : "frame_end");
        $display("frame %0d done dispatched=%0d", frames, m_disp);
        return;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_outs(tag, 1'b0, 1'b0, '0, 1'b0);
    check_entry(tag, IDX_NULL, 64'd0, 64'd0);
    check({tag, ".dispatched"}, 64'(dispatched), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.coord_valid = 1'b0;
    bus_if.coord_idx   = '0;
    bus_if.coord_x0    = '0;
    bus_if.coord_y0    = '0;
    bus_if.worker_read = '0;
    repeat (3) cycle();
    reset = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
    check_reset_values("reset");

    // Only worker 2 reads: offers 0001, 0010, 0100; next frame starts at 1000
    run_frame(1, 0, 0, 2, 0, 1'b0);
    run_frame(1, 0, 0, -1, 0, 1'b0);
    // Back-to-back frame at peak rate
    run_frame(3, 0, 0, -1, 0, 1'b0);
    // Abort together with a read: entry still dispatched, frame ends after HOLD
    run_frame(4, 3, 0, -1, 1, 1'b0);
    check("abort_read.dispatched", 64'(dispatched), 64'd1);
    // Wrong worker reads: ignored, sticky error, rotation continues
    run_frame(2, 0, 0, -1, 1, 1'b1);
    run_frame(0, 0, 0, 0, 0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      int cnt;
      cnt = $urandom_range(0, 5);
      run_frame(cnt, $urandom_range(0, 4), (cnt > 0) ? int'($urandom_range(0, cnt - 1)) : 0,
                NW, 2, 1'($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset in the middle of an offer with the pointer at 2
    while (m_ptr != 2) run_frame(1, 0, 0, -1, 0, 1'b0);
    frame_count = IDX_WIDTH'(2);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    bus_if.coord_valid = 1'b1;
    bus_if.coord_idx   = IDX_WIDTH'(5);
    bus_if.coord_x0    = 64'h1234;
    bus_if.coord_y0    = 64'h5678;
    cycle();
    bus_if.coord_valid = 1'b0;
    check("pre_reset.poll_ready", 64'(bus_if.poll_ready), 64'(4'b0100));
    #2 reset = 1'b1;
    #1;
    m_ptr = 0;
    m_err = 1'b0;
    check_reset_values("async_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    cycle();
    check_reset_values("after_reset");
    run_frame(1, 0, 0, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
